mem_ctrl: RTL and testbench

Memory-side responder for the ME stage RAM port. It accepts one word-level load or masked store from ME and serialises it onto a byte-wide synchronous RAM. `busy_o` stalls ME while a transaction is in flight; `done_o` returns load data to ME. It sits between ME and the on-board byte RAM, opposite the ME stage's request signals.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_ctrl_if.sv | 21 ++
 rtl/mem_ctrl_lane_sel.sv | 32 +++
 rtl/mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the ME-stage byte-RAM responder: FSM states, byte bus and lane index.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MemCtrlIdle = 2'd0,
        MemCtrlRd   = 2'd1,
        MemCtrlDone = 2'd2,
        MemCtrlWr   = 2'd3
    } state_t;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    typedef logic [BYTE_W-1:0] byte_bus_t;
    typedef logic [1:0]        lane_t;

    localparam byte_bus_t BYTE_ZERO = '0;

endpackage

// File: rtl/mem_ctrl_if.sv
// ME-stage request/response bundle; the ME stage is the master, mem_ctrl the slave.
interface mem_ctrl_if;
    logic        r_enable_i;
    logic        w_enable_i;
    logic [3:0]  w_mask_i;
    logic [31:0] w_data_i;
    logic [31:0] addr_i;
    logic [31:0] r_data_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        output r_enable_i, w_enable_i, w_mask_i, w_data_i, addr_i,
        input  r_data_o, busy_o, done_o
    );

    modport slave (
        input  r_enable_i, w_enable_i, w_mask_i, w_data_i, addr_i,
        output r_data_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_ctrl_lane_sel.sv
// Picks the first store lane at or after i_from. MEM_CTRL_MASK_SKIP_EN skips masked-off lanes;
// otherwise every lane is visited in order and o_wr reports whether it is actually written.
module mem_ctrl_lane_sel
    import mem_ctrl_pkg::*;
(
    input  logic [3:0] i_mask,
    input  logic [2:0] i_from,
    output lane_t      o_lane,
    output logic       o_found,
    output logic       o_wr
);

`ifdef MEM_CTRL_MASK_SKIP_EN
    // Descending scan so the lowest qualifying lane is the one left standing.
    always_comb begin
        o_lane  = '0;
        o_found = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i] && (3'(i) >= i_from)) begin
                o_lane  = lane_t'(i);
                o_found = 1'b1;
            end
        end
    end
`else
    assign o_lane  = i_from[1:0];
    assign o_found = ~i_from[2];
`endif

    assign o_wr = o_found & i_mask[o_lane];

endmodule

// File: rtl/mem_ctrl.sv
// Serialises one word load or masked store from ME onto a byte-wide synchronous RAM.
// Optional MEM_CTRL_MASK_SKIP_EN: stores visit only enabled lanes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_ctrl_if.slave             me,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wr_o,
    output byte_bus_t             mem_dout_o,
    input  byte_bus_t             mem_din_i
);

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [3:0]            r_mask;
    logic [31:0]           r_wdata;
    lane_t                 r_lane;
    logic [31:0]           r_rdata;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr;
    byte_bus_t             r_dout;

    logic [ADDR_WIDTH-1:0] w_base_in;
    lane_t                 w_first_lane;
    logic                  w_first_found;
    logic                  w_first_wr;
    lane_t                 w_adv_lane;
    logic                  w_adv_found;
    logic                  w_adv_wr;
    logic [2:0]            w_adv_from;
    lane_t                 w_cap_lane;
    byte_bus_t             w_first_byte;
    byte_bus_t             w_next_byte;
    logic                  w_unused;

    assign w_base_in    = {me.addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_adv_from   = {1'b0, r_lane} + 3'd1;
    // Byte for address base+k arrives while cnt = k+1.
    assign w_cap_lane   = r_cnt[1:0] - 2'd1;
    assign w_first_byte = me.w_data_i[{w_first_lane, 3'b000} +: BYTE_W];
    assign w_next_byte  = r_wdata[{w_adv_lane, 3'b000} +: BYTE_W];
    assign w_unused     = &{1'b0, me.addr_i[31:ADDR_WIDTH], me.addr_i[1:0], w_first_found};

    mem_ctrl_lane_sel u_first_sel (
        .i_mask  (me.w_mask_i),
        .i_from  (3'd0),
        .o_lane  (w_first_lane),
        .o_found (w_first_found),
        .o_wr    (w_first_wr)
    );

    mem_ctrl_lane_sel u_adv_sel (
        .i_mask  (r_mask),
        .i_from  (w_adv_from),
        .o_lane  (w_adv_lane),
        .o_found (w_adv_found),
        .o_wr    (w_adv_wr)
    );

    // Outputs are registered alongside the state so the RAM side never sees a combinational path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MemCtrlIdle;
            r_cnt   <= '0;
            r_base  <= '0;
            r_mask  <= '0;
            r_wdata <= '0;
            r_lane  <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_dout  <= BYTE_ZERO;
        end else begin
            case (r_state)
                MemCtrlIdle: begin
                    r_done <= 1'b0;
                    if (me.r_enable_i) begin
                        r_state <= MemCtrlRd;
                        r_base  <= w_base_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_addr  <= w_base_in;
                        r_wr    <= 1'b0;
                        r_dout  <= BYTE_ZERO;
                    end else if (me.w_enable_i && (me.w_mask_i != 4'd0)) begin
                        r_state <= MemCtrlWr;
                        r_base  <= w_base_in;
                        r_mask  <= me.w_mask_i;
                        r_wdata <= me.w_data_i;
                        r_lane  <= w_first_lane;
                        r_busy  <= 1'b1;
                        r_addr  <= w_base_in + ADDR_WIDTH'(w_first_lane);
                        r_wr    <= w_first_wr;
                        r_dout  <= w_first_byte;
                    end else begin
                        r_busy  <= 1'b0;
                        r_addr  <= r_base;
                        r_wr    <= 1'b0;
                        r_dout  <= BYTE_ZERO;
                    end
                end
                MemCtrlRd: begin
                    if (r_cnt != 3'd0) begin
                        r_rdata[{w_cap_lane, 3'b000} +: BYTE_W] <= mem_din_i;
                    end
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd4) begin
                        r_state <= MemCtrlDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_addr  <= r_base;
                    end else if (r_cnt == 3'd3) begin
                        r_addr  <= r_base;
                    end else begin
                        r_addr  <= r_base + ADDR_WIDTH'(r_cnt + 3'd1);
                    end
                end
                MemCtrlDone: begin
                    r_state <= MemCtrlIdle;
                    r_done  <= 1'b0;
                end
                MemCtrlWr: begin
                    if (w_adv_found) begin
                        r_lane <= w_adv_lane;
                        r_addr <= r_base + ADDR_WIDTH'(w_adv_lane);
                        r_wr   <= w_adv_wr;
                        r_dout <= w_next_byte;
                    end else begin
                        r_state <= MemCtrlIdle;
                        r_busy  <= 1'b0;
                        r_addr  <= r_base;
                        r_wr    <= 1'b0;
                        r_dout  <= BYTE_ZERO;
                    end
                end
                default: r_state <= MemCtrlIdle;
            endcase
        end
    end

    assign me.r_data_o = r_rdata;
    assign me.busy_o   = r_busy;
    assign me.done_o   = r_done;
    assign mem_addr_o  = r_addr;
    assign mem_wr_o    = r_wr;
    assign mem_dout_o  = r_dout;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model plus a word-level reference memory, directed and random traffic.
module tb_mem_ctrl;
    localparam int AW    = 17;
    localparam int MEMSZ = 1 << AW;
`ifdef MEM_CTRL_MASK_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_addr_o;
    logic          mem_wr_o;
    logic [7:0]    mem_dout_o;
    logic [7:0]    mem_din_i;

    mem_ctrl_if bus();

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .me         (bus),
        .mem_addr_o (mem_addr_o),
        .mem_wr_o   (mem_wr_o),
        .mem_dout_o (mem_dout_o),
        .mem_din_i  (mem_din_i)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [MEMSZ];
    logic [7:0] ref_mem [MEMSZ];
    logic       init_ram = 1'b0;

    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < MEMSZ; i++) ram[i] <= ref_mem[i];
        end else if (mem_wr_o) begin
            ram[mem_addr_o] <= mem_dout_o;
        end
        mem_din_i <= ram[mem_addr_o];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t wr_log[$];
    wr_t exp_wr[$];
    int  n_cmp    = 0;
    int  n_err    = 0;
    int  done_cnt = 0;
    int  cyc      = 0;

    function automatic logic [AW-1:0] lane_addr(input logic [31:0] a, input int i);
        logic [AW-1:0] b;
        b       = a[AW-1:0];
        b[1:0]  = 2'b00;
        return b + AW'(i);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[lane_addr(a, i)];
        return w;
    endfunction

    function automatic int exp_cycles(input logic [3:0] m);
        return SKIP ? $countones(m) : 4;
    endfunction

    function automatic logic [3:0] exp_pat(input logic [3:0] m);
        return SKIP ? 4'((1 << $countones(m)) - 1) : m;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                ref_mem[lane_addr(a, i)] = d[8*i +: 8];
                exp_wr.push_back('{lane_addr(a, i), d[8*i +: 8]});
            end
        end
    endtask

    task automatic wr_diff(output int diff);
        diff = 0;
        if (wr_log.size() != exp_wr.size()) diff = 1 + wr_log.size();
        else for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== exp_wr[i]) diff++;
        wr_log.delete();
        exp_wr.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
        if (bus.done_o === 1'b1) done_cnt++;
        if (mem_wr_o === 1'b1) wr_log.push_back('{mem_addr_o, mem_dout_o});
    endtask

    task automatic wait_idle(output int waited);
        waited = 0;
        while ((bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout cycle=%0d busy=%b required_busy=0", cyc, bus.busy_o);
        end
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] data, output int lat,
                           output int wait_n, output int addr_err, output int busy_n);
        bus.r_enable_i = 1'b1;
        bus.addr_i     = a;
        wait_idle(wait_n);
        data = '0; lat = 0; addr_err = 0; busy_n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                bus.r_enable_i = 1'b0;
                bus.w_enable_i = 1'b0;
            end
            if (bus.busy_o === 1'b1) busy_n++;
            if (k <= 4 && (mem_addr_o !== lane_addr(a, k - 1) || mem_wr_o !== 1'b0)) addr_err++;
            if (bus.done_o === 1'b1) begin
                lat  = k;
                data = bus.r_data_o;
                break;
            end
        end
        $display("[%0d] LOAD  addr=%h data=%h lat=%0d wait=%0d", cyc, a, data, lat, wait_n);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                            input bit early, output int wait_n, output int busy_n,
                            output logic [3:0] pat, output int done_seen);
        int d0;
        bus.w_enable_i = 1'b1;
        bus.w_mask_i   = m;
        bus.w_data_i   = d;
        bus.addr_i     = a;
        wait_idle(wait_n);
        d0 = done_cnt; busy_n = 0; pat = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) bus.w_enable_i = 1'b0;
            if (bus.busy_o !== 1'b1) break;
            busy_n++;
            if (k <= 4 && mem_wr_o === 1'b1) pat[k-1] = 1'b1;
            if (early) break;
        end
        done_seen = done_cnt - d0;
        $display("[%0d] STORE addr=%h mask=%b data=%h busy=%0d pat=%b", cyc, a, m, d, busy_n, pat);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick();
        n_cmp += 6;
        if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
        if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", bus.done_o); end
        if (bus.r_data_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", bus.r_data_o); end
        if (mem_wr_o !== 1'b0) begin n_err++; $display("FAIL rst_wr got=%b exp=0", mem_wr_o); end
        if (mem_addr_o !== '0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", mem_addr_o); end
        if (mem_dout_o !== 8'h0) begin n_err++; $display("FAIL rst_dout got=%h exp=0", mem_dout_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_word();
        logic [31:0] data; int lat, wn, ae, bn;
        do_load(32'h104, data, lat, wn, ae, bn);
        n_cmp += 4;
        if (data !== 32'h44332211) begin n_err++; $display("FAIL lw_data got=%h exp=44332211", data); end
        if (lat !== 6) begin n_err++; $display("FAIL lw_latency got=%0d exp=6", lat); end
        if (ae !== 0) begin n_err++; $display("FAIL lw_addr_seq bad_cycles=%0d exp=0", ae); end
        if (bn !== 5) begin n_err++; $display("FAIL lw_busy_cycles got=%0d exp=5", bn); end
        do_load(32'h107, data, lat, wn, ae, bn);
        n_cmp += 3;
        if (data !== 32'h44332211) begin n_err++; $display("FAIL lb_data got=%h exp=44332211", data); end
        if (lat !== 6) begin n_err++; $display("FAIL lb_latency got=%0d exp=6", lat); end
        if (ae !== 0) begin n_err++; $display("FAIL lb_addr_seq bad_cycles=%0d exp=0", ae); end
    endtask

    task automatic test_store_byte();
        logic [31:0] data; int lat, wn, ae, bn, ds, diff; logic [3:0] pat;
        ref_store(32'h202, 4'b0100, 32'hABABABAB);
        do_store(32'h202, 4'b0100, 32'hABABABAB, 1'b0, wn, bn, pat, ds);
        wr_diff(diff);
        n_cmp += 4;
        if (diff !== 0) begin n_err++; $display("FAIL sb_writes diff=%0d exp=0", diff); end
        if (bn !== exp_cycles(4'b0100)) begin n_err++; $display("FAIL sb_busy got=%0d exp=%0d", bn, exp_cycles(4'b0100)); end
        if (pat !== exp_pat(4'b0100)) begin n_err++; $display("FAIL sb_wr_pattern got=%b exp=%b", pat, exp_pat(4'b0100)); end
        if (ds !== 0) begin n_err++; $display("FAIL sb_done got=%0d exp=0", ds); end
        do_load(32'h200, data, lat, wn, ae, bn);
        n_cmp++;
        if (data !== ref_word(32'h200)) begin n_err++; $display("FAIL sb_readback got=%h exp=%h", data, ref_word(32'h200)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data; int lat, wn, ae, bn, ds, diff, d0; logic [3:0] pat;
        d0 = done_cnt;
        ref_store(32'h300, 4'b1111, 32'hDEADBEEF);
        do_store(32'h300, 4'b1111, 32'hDEADBEEF, 1'b1, wn, bn, pat, ds);
        do_load(32'h300, data, lat, wn, ae, bn);
        wr_diff(diff);
        n_cmp += 5;
        if (wn !== 4) begin n_err++; $display("FAIL b2b_wait got=%0d exp=4", wn); end
        if (data !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_data got=%h exp=deadbeef", data); end
        if (lat !== 6) begin n_err++; $display("FAIL b2b_latency got=%0d exp=6", lat); end
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt - d0); end
        if (diff !== 0) begin n_err++; $display("FAIL b2b_writes diff=%0d exp=0", diff); end
    endtask

    task automatic test_mask_zero_priority();
        logic [31:0] data; int lat, wn, ae, bn, diff, d0;
        d0 = done_cnt;
        bus.w_enable_i = 1'b1; bus.w_mask_i = 4'b0000; bus.w_data_i = 32'h12345678; bus.addr_i = 32'h500;
        tick();
        bus.w_enable_i = 1'b0;
        n_cmp += 2;
        if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL mask0_busy got=%b exp=0", bus.busy_o); end
        tick();
        if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL mask0_done got=%0d exp=0", done_cnt - d0); end
        bus.w_enable_i = 1'b1; bus.w_mask_i = 4'b1111; bus.w_data_i = 32'h55AA55AA;
        do_load(32'h104, data, lat, wn, ae, bn);
        wr_diff(diff);
        n_cmp += 3;
        if (data !== ref_word(32'h104)) begin n_err++; $display("FAIL prio_data got=%h exp=%h", data, ref_word(32'h104)); end
        if (lat !== 6) begin n_err++; $display("FAIL prio_latency got=%0d exp=6", lat); end
        if (diff !== 0) begin n_err++; $display("FAIL prio_no_write diff=%0d exp=0", diff); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] data; int lat, wn, ae, bn, d0;
        bus.r_enable_i = 1'b1; bus.addr_i = 32'h104;
        wait_idle(wn);
        tick();
        bus.r_enable_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp += 6;
        if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.busy_o); end
        if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", bus.done_o); end
        if (bus.r_data_o !== 32'h0) begin n_err++; $display("FAIL abort_rdata got=%h exp=0", bus.r_data_o); end
        if (mem_addr_o !== '0) begin n_err++; $display("FAIL abort_addr got=%h exp=0", mem_addr_o); end
        if (mem_wr_o !== 1'b0) begin n_err++; $display("FAIL abort_wr got=%b exp=0", mem_wr_o); end
        d0 = done_cnt;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL abort_late_done got=%0d exp=0", done_cnt - d0); end
        do_load(32'h104, data, lat, wn, ae, bn);
        n_cmp += 2;
        if (data !== ref_word(32'h104)) begin n_err++; $display("FAIL abort_reload got=%h exp=%h", data, ref_word(32'h104)); end
        if (lat !== 6) begin n_err++; $display("FAIL abort_reload_lat got=%0d exp=6", lat); end
        // A store cut by reset while its strobe is high must drop the strobe without a clock edge.
        bus.w_enable_i = 1'b1; bus.w_mask_i = 4'b0001; bus.w_data_i = $urandom(); bus.addr_i = 32'h400;
        wait_idle(wn);
        tick();
        bus.w_enable_i = 1'b0;
        n_cmp += 3;
        if (mem_wr_o !== 1'b1) begin n_err++; $display("FAIL abort_st_wr_before got=%b exp=1", mem_wr_o); end
        rst = 1'b0;
        #1;
        if (mem_wr_o !== 1'b0) begin n_err++; $display("FAIL abort_st_wr_async got=%b exp=0", mem_wr_o); end
        tick();
        rst = 1'b1;
        tick();
        wr_log.delete();
        do_load(32'h400, data, lat, wn, ae, bn);
        if (data !== ref_word(32'h400)) begin n_err++; $display("FAIL abort_st_nowrite got=%h exp=%h", data, ref_word(32'h400)); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, data; logic [AW-1:0] off; logic [3:0] m, pat;
        int lat, wn, ae, bn, ds, diff;
        for (int n = 0; n < 40; n++) begin
            if (n % 3 == 0) off = 17'h1FFF0 + 17'($urandom_range(0, 15));
            else off = 17'h1000 + 17'($urandom_range(0, 63));
            a = $urandom();
            a[AW-1:0] = off;
            if ($urandom_range(0, 1) == 0) begin
                do_load(a, data, lat, wn, ae, bn);
                n_cmp += 3;
                if (data !== ref_word(a)) begin n_err++; $display("FAIL rnd_load_data a=%h got=%h exp=%h", a, data, ref_word(a)); end
                if (lat !== 6) begin n_err++; $display("FAIL rnd_load_lat a=%h got=%0d exp=6", a, lat); end
                if (ae !== 0) begin n_err++; $display("FAIL rnd_load_addr a=%h bad_cycles=%0d exp=0", a, ae); end
            end else begin
                m = 4'($urandom_range(1, 15));
                d = $urandom();
                ref_store(a, m, d);
                do_store(a, m, d, 1'b0, wn, bn, pat, ds);
                wr_diff(diff);
                n_cmp += 4;
                if (diff !== 0) begin n_err++; $display("FAIL rnd_store_writes a=%h diff=%0d exp=0", a, diff); end
                if (bn !== exp_cycles(m)) begin n_err++; $display("FAIL rnd_store_busy got=%0d exp=%0d", bn, exp_cycles(m)); end
                if (pat !== exp_pat(m)) begin n_err++; $display("FAIL rnd_store_pattern got=%b exp=%b", pat, exp_pat(m)); end
                if (ds !== 0) begin n_err++; $display("FAIL rnd_store_done got=%0d exp=0", ds); end
            end
        end
    endtask

    initial begin
        bus.r_enable_i = 1'b0;
        bus.w_enable_i = 1'b0;
        bus.w_mask_i   = 4'b0000;
        bus.w_data_i   = 32'h0;
        bus.addr_i     = 32'h0;
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom());
        ref_mem[17'h104] = 8'h11;
        ref_mem[17'h105] = 8'h22;
        ref_mem[17'h106] = 8'h33;
        ref_mem[17'h107] = 8'h44;
        init_ram = 1'b1;
        #1 rst = 1'b0;
        tick();
        init_ram = 1'b0;
        wr_log.delete();
        test_reset();
        test_load_word();
        test_store_byte();
        test_back_to_back();
        test_mask_zero_priority();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d limit_reached", cyc);
        $fatal(1, "watchdog");
    end

endmodule
